vmem_sequencer: RTL and testbench
=================================

// Module: vmem_sequencer
// PURPOSE
//  Sequences one M-type vector load/store at a time between a scratchpad (sp0/sp1) and the vector register file.
//  Decodes the 32-bit M-type word and generates NUM_BEATS row accesses with row/column stride, optional swizzle and per-beat mask.
//  Loads are pipelined, with up to MAX_OUT requests outstanding. Stores read the VRF and then write the scratchpad, one beat at a time.
//  Sits between vector decode/issue and the scratchpad ports.
// PARAMETERS
//  ADDR_W     16          scratchpad word address width
//  DATA_W     128         beat (one vector row) width
//  NUM_BEATS  16          beats per vector register; BEAT_W = $clog2(NUM_BEATS)
//  ROW_STRIDE 1           address step per beat, transpose=0
//  COL_STRIDE 16          address step per beat, transpose=1
//  SWZ_W      4           low address bits XORed with beat index when swizzle=1
//  MAX_OUT    4           max outstanding load requests (power of 2)
//  OP_VLOAD   7'b0000111  load opcode
//  OP_VSTORE  7'b0100111  store opcode
// PORTS
//  CLK          in   1          clock
//  nRST         in   1          async active-low reset
//  instr_valid  in   1          instruction offered
//  instr_ready  out  1          accept; high only in IDLE
//  instr        in   32         M-type: [31]swizzle [30]transpose [29:28]dtype [27:20]vd [19]mask [18:11]rs1 [10]sp [9:3]opcode [2:0]rsvd
//  base_addr    in   ADDR_W     value of rs1, sampled at accept
//  vmask        in   NUM_BEATS  beat enables, sampled at accept
//  sp_req       out  1          scratchpad request
//  sp_sel       out  1          0=sp0, 1=sp1
//  sp_we        out  1          1=write (store)
//  sp_addr      out  ADDR_W     request address
//  sp_wdata     out  DATA_W     store data
//  sp_gnt       in   1          request accepted this cycle
//  sp_rvalid    in   1          load data valid; in order, >=1 cycle after gnt
//  sp_rdata     in   DATA_W     load data
//  vrf_re       out  1          VRF read strobe; vrf_rdata valid the next cycle
//  vrf_we       out  1          VRF write strobe
//  vrf_vd       out  8          target/source vector register
//  vrf_beat     out  BEAT_W     beat index for read/write
//  vrf_wdata    out  DATA_W     write data
//  vrf_rdata    in   DATA_W     read data
//  busy         out  1          not IDLE
//  done         out  1          1-cycle pulse, instruction complete
//  err          out  1          1-cycle pulse, illegal opcode
// BEHAVIOUR
//  Reset (async, nRST=0): state IDLE; all outputs 0 except instr_ready=1. Beat/outstanding counters and tag FIFO cleared.
//  Accept = instr_valid & instr_ready. On accept, latch fields, base_addr and vmask (vmask is forced to all-ones when mask=0).
//  Address of beat b: (base + b*STRIDE) mod 2^ADDR_W; when swizzle=1, [SWZ_W-1:0] is then XORed with b[SWZ_W-1:0]. dtype is ignored.
//  Masked-off beats are skipped: no sp request, no VRF access, no cycles spent.
//  FSM states:
//   IDLE    accept -> LD (opcode OP_VLOAD), ST_RD (OP_VSTORE), or ERR (any other opcode).
//   LD      sp_req=1 while beats remain and outstanding<MAX_OUT, at the next enabled beat.
//           On gnt: push beat index into the tag FIFO, outstanding++.
//           On rvalid: pop tag; vrf_we=1 same cycle, with vrf_beat=tag and vrf_wdata=sp_rdata; outstanding--.
//           gnt and rvalid in the same cycle leave outstanding unchanged.
//           Once all beats are issued and outstanding==0 -> DONE.
//   ST_RD   vrf_re=1 for the current beat -> ST_WR.
//   ST_WR   sp_req=1, sp_we=1, sp_wdata=vrf_rdata, captured on entry and held until gnt.
//           On gnt: go to ST_RD for the next enabled beat, or DONE if none remain.
//   DONE    done=1 for one cycle -> IDLE.
//   ERR     err=1 for one cycle -> IDLE.
//  All-zero vmask with mask=1: LD/ST go directly to DONE on the next cycle (latency 2 from accept).
//  sp_req, sp_addr, sp_we and sp_wdata are held stable until gnt.
//  sp_rvalid while outstanding==0 is ignored.
//  Ideal load latency (gnt same cycle, rvalid 1 cycle later, MAX_OUT not reached): accept at T, reqs T+1..T+16, last write T+17, done T+18.
//  Reset mid-operation: instruction abandoned; responses that arrive later are ignored (outstanding=0).
// TESTING
//  1 Load, sp=0, base=0x0100, mask=0, gnt tied 1, rvalid 1 cycle later
//    -> sp_addr 0x0100..0x010F, 16 vrf writes beats 0..15, done at T+18.
//  2 Load, transpose=1, base=0x0100 -> sp_addr 0x0100,0x0110,...,0x01F0; wraps mod 2^16 when base=0xFF80.
//  3 Load, mask=1, vmask=0x0005 -> exactly 2 requests (0x0100, 0x0102), vrf_beat 0 and 2, done.
//  4 Load with gnt=1 and rvalid held 0 -> sp_req drops after 4 grants.
//    Release rvalid -> remaining beats issue, 16 writes in order.
//  5 Store, sp=1, swizzle=1, base=0x0200, vrf_rdata=beat id
//    -> sp_sel=1, addr(b)=0x0200+b with low 4 bits ^b, wdata==b, gnt delay of 3 holds request stable.
//  6 Opcode 7'h7F -> err pulse, no sp_req. Separately: nRST low mid-load -> outputs 0 immediately; a late rvalid causes no vrf_we.

Source files
------------

// File: rtl/vmem_sequencer.sv
// rtl/vmem_sequencer.sv - M-type vector load/store sequencer between scratchpad and vector register file
module vmem_sequencer #(
    parameter int          ADDR_W     = 16,
    parameter int          DATA_W     = 128,
    parameter int          NUM_BEATS  = 16,
    parameter int          ROW_STRIDE = 1,
    parameter int          COL_STRIDE = 16,
    parameter int          SWZ_W      = 4,
    parameter int          MAX_OUT    = 4,
    parameter logic [6:0]  OP_VLOAD   = 7'b0000111,
    parameter logic [6:0]  OP_VSTORE  = 7'b0100111,
    localparam int         BEAT_W     = $clog2(NUM_BEATS)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [31:0]          instr,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [NUM_BEATS-1:0] vmask,
    output logic                 sp_req,
    output logic                 sp_sel,
    output logic                 sp_we,
    output logic [ADDR_W-1:0]    sp_addr,
    output logic [DATA_W-1:0]    sp_wdata,
    input  logic                 sp_gnt,
    input  logic                 sp_rvalid,
    input  logic [DATA_W-1:0]    sp_rdata,
    output logic                 vrf_re,
    output logic                 vrf_we,
    output logic [7:0]           vrf_vd,
    output logic [BEAT_W-1:0]    vrf_beat,
    output logic [DATA_W-1:0]    vrf_wdata,
    input  logic [DATA_W-1:0]    vrf_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [ADDR_W-1:0] ROW_S    = ADDR_W'(ROW_STRIDE);
    localparam logic [ADDR_W-1:0] COL_S    = ADDR_W'(COL_STRIDE);
    localparam logic [ADDR_W-1:0] SWZ_MASK = ADDR_W'((1 << SWZ_W) - 1);
    localparam logic [CNT_W-1:0]  OUT_MAX  = CNT_W'(MAX_OUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LD, S_ST_RD, S_ST_WR, S_DONE, S_ERR
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_BEATS-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]     out_q, out_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [BEAT_W-1:0]    tag_q [MAX_OUT];
    logic [ADDR_W-1:0]    base_q;
    logic [7:0]           vd_q;
    logic                 sel_q, swz_q, trans_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 wr_first_q;

    logic                 accept, push, pop;
    logic [BEAT_W-1:0]    cur_beat;
    logic [NUM_BEATS-1:0] rem_clr;
    logic [ADDR_W-1:0]    beat_ext, stride, addr_lin, cur_addr;
    logic                 unused_ok;

    // dtype and reserved bits carry no meaning for this block
    assign unused_ok = &{1'b0, instr[29:28], instr[2:0]};

    assign accept = instr_valid && (state_q == S_IDLE);
    assign busy   = (state_q != S_IDLE);

    // Next beat to handle is the lowest still-pending enabled beat; skipped beats cost no cycles
    always_comb begin
        cur_beat = '0;
        for (int i = NUM_BEATS - 1; i >= 0; i--) begin
            if (rem_q[i]) cur_beat = BEAT_W'(i);
        end
        rem_clr  = rem_q & ~(NUM_BEATS'(1) << cur_beat);
        beat_ext = ADDR_W'(cur_beat);
        stride   = trans_q ? COL_S : ROW_S;
        addr_lin = base_q + beat_ext * stride;
        cur_addr = swz_q ? (addr_lin ^ (beat_ext & SWZ_MASK)) : addr_lin;
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        instr_ready = 1'b0;
        sp_req      = 1'b0;
        sp_sel      = 1'b0;
        sp_we       = 1'b0;
        sp_addr     = '0;
        sp_wdata    = '0;
        vrf_re      = 1'b0;
        vrf_we      = 1'b0;
        vrf_vd      = '0;
        vrf_beat    = '0;
        vrf_wdata   = '0;
        done        = 1'b0;
        err         = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    rem_d = instr[19] ? vmask : '1;
                    if (instr[9:3] == OP_VLOAD)       state_d = S_LD;
                    else if (instr[9:3] == OP_VSTORE) state_d = S_ST_RD;
                    else                              state_d = S_ERR;
                end
            end
            S_LD: begin
                sp_req  = (rem_q != '0) && (out_q < OUT_MAX);
                sp_sel  = sp_req & sel_q;
                sp_addr = sp_req ? cur_addr : '0;
                push    = sp_req && sp_gnt;
                pop     = sp_rvalid && (out_q != '0);
                if (push) rem_d = rem_clr;
                if (pop) begin
                    vrf_we    = 1'b1;
                    vrf_vd    = vd_q;
                    vrf_beat  = tag_q[rd_ptr_q];
                    vrf_wdata = sp_rdata;
                end
                if ((rem_d == '0) && (out_d == '0)) state_d = S_DONE;
            end
            S_ST_RD: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    vrf_re   = 1'b1;
                    vrf_vd   = vd_q;
                    vrf_beat = cur_beat;
                    state_d  = S_ST_WR;
                end
            end
            S_ST_WR: begin
                sp_req   = 1'b1;
                sp_we    = 1'b1;
                sp_sel   = sel_q;
                sp_addr  = cur_addr;
                sp_wdata = wr_first_q ? vrf_rdata : wdata_q;
                if (sp_gnt) begin
                    rem_d   = rem_clr;
                    state_d = (rem_clr == '0) ? S_DONE : S_ST_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outstanding count: a grant and a response in the same cycle cancel out
    always_comb begin
        out_d = out_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state, beat bookkeeping and store-data capture
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            out_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_first_q <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            out_q      <= out_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            wr_first_q <= (state_q == S_ST_RD) && (state_d == S_ST_WR);
            if (wr_first_q) wdata_q <= vrf_rdata;
        end
    end

    // Instruction fields captured at accept
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            base_q  <= '0;
            vd_q    <= '0;
            sel_q   <= 1'b0;
            swz_q   <= 1'b0;
            trans_q <= 1'b0;
        end else if (accept) begin
            base_q  <= base_addr;
            vd_q    <= instr[27:20];
            sel_q   <= instr[10];
            swz_q   <= instr[31];
            trans_q <= instr[30];
        end
    end

    // Tag FIFO: beat index of each granted load, popped in order by responses
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < MAX_OUT; i++) tag_q[i] <= '0;
        end else if (push) begin
            tag_q[wr_ptr_q] <= cur_beat;
        end
    end

endmodule

// File: tb/tb_vmem_sequencer.sv
// tb/tb_vmem_sequencer.sv - randomized self-checking bench for vmem_sequencer
module tb_vmem_sequencer;
    localparam int DW = 128;
    localparam logic [6:0] OP_LD = 7'b0000111;
    localparam logic [6:0] OP_ST = 7'b0100111;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          instr_valid, instr_ready;
    logic [31:0]   instr;
    logic [15:0]   base_addr, vmask;
    logic          sp_req, sp_sel, sp_we, sp_gnt, sp_rvalid;
    logic [15:0]   sp_addr;
    logic [DW-1:0] sp_wdata, sp_rdata, vrf_wdata, vrf_rdata;
    logic          vrf_re, vrf_we, busy, done, err;
    logic [7:0]    vrf_vd;
    logic [3:0]    vrf_beat;

    vmem_sequencer dut (
        .CLK(CLK), .nRST(nRST), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .base_addr(base_addr), .vmask(vmask),
        .sp_req(sp_req), .sp_sel(sp_sel), .sp_we(sp_we), .sp_addr(sp_addr), .sp_wdata(sp_wdata),
        .sp_gnt(sp_gnt), .sp_rvalid(sp_rvalid), .sp_rdata(sp_rdata),
        .vrf_re(vrf_re), .vrf_we(vrf_we), .vrf_vd(vrf_vd), .vrf_beat(vrf_beat),
        .vrf_wdata(vrf_wdata), .vrf_rdata(vrf_rdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    logic [15:0]   o_addr[$];
    logic          o_sel[$];
    logic [DW-1:0] o_sdata[$];
    logic [3:0]    o_vbeat[$];
    logic [7:0]    o_vvd[$];
    logic [DW-1:0] o_vdata[$];
    logic [3:0]    o_rbeat[$];
    logic [7:0]    o_rvd[$];
    logic [DW-1:0] exp_ld[$];
    int            exp_beats[$];
    logic [15:0]   exp_addr[$];
    int            done_cyc, err_cyc, max_outs, hold_grants;
    bit            unstable, req_in_hold, timeout;

    function automatic logic [31:0] mk_instr(input logic swz, input logic trans, input logic [7:0] vd,
                                             input logic msk, input logic sp, input logic [6:0] op);
        return {swz, trans, 2'($urandom), vd, msk, 8'($urandom), sp, op, 3'($urandom)};
    endfunction

    function automatic logic [DW-1:0] vrf_val(input logic [7:0] vd, input logic [3:0] b);
        return {56'h0, vd, 60'h0, b};
    endfunction

    // Reference: enabled beats in ascending order and their scratchpad addresses
    task automatic model(input logic [31:0] ins, input logic [15:0] base, input logic [15:0] vm);
        logic [15:0] a;
        exp_beats.delete();
        exp_addr.delete();
        for (int b = 0; b < 16; b++) begin
            if (!ins[19] || vm[b]) begin
                a = base + 16'(b) * (ins[30] ? 16'd16 : 16'd1);
                if (ins[31]) a = a ^ 16'(b & 15);
                exp_beats.push_back(b);
                exp_addr.push_back(a);
            end
        end
    endtask

    // Issues one instruction and plays scratchpad and VRF, logging what the DUT does
    task automatic run_op(input logic [31:0] ins, input logic [15:0] base, input logic [15:0] vm,
                          input int gdel, input int rlat, input int hold_until);
        int pend_due[$];
        logic [DW-1:0] pend_data[$];
        logic [DW-1:0] d;
        int outs = 0;
        int wait_cnt = 0;
        bit prev_pend = 0;
        bit rd_pend = 0;
        logic [15:0] pa;
        logic pwe, psel;
        logic [DW-1:0] pwd;
        logic [7:0] rvd;
        logic [3:0] rb;
        o_addr.delete(); o_sel.delete(); o_sdata.delete(); o_vbeat.delete(); o_vvd.delete();
        o_vdata.delete(); o_rbeat.delete(); o_rvd.delete(); exp_ld.delete();
        done_cyc = -1; err_cyc = -1; max_outs = 0; hold_grants = -1;
        unstable = 0; req_in_hold = 0; timeout = 0;
        @(negedge CLK);
        instr_valid = 1'b1; instr = ins; base_addr = base; vmask = vm;
        sp_gnt = 1'b0; sp_rvalid = 1'b0;
        @(posedge CLK);
        #1;
        instr_valid = 1'b0; instr = $urandom; base_addr = 16'($urandom); vmask = 16'($urandom);
        cyc = 0;
        while (cyc < 400 && done_cyc < 0 && err_cyc < 0) begin
            @(negedge CLK);
            cyc++;
            vrf_rdata = rd_pend ? vrf_val(rvd, rb) : {$urandom, $urandom, $urandom, $urandom};
            if (pend_due.size() > 0 && pend_due[0] <= cyc && cyc >= hold_until) begin
                sp_rvalid = 1'b1;
                sp_rdata  = pend_data.pop_front();
                void'(pend_due.pop_front());
                outs--;
            end else begin
                sp_rvalid = (outs == 0) && ($urandom_range(0, 3) == 0);
                sp_rdata  = {$urandom, $urandom, $urandom, $urandom};
            end
            sp_gnt = sp_req && (wait_cnt >= gdel);
            #1;
            if (prev_pend && (!sp_req || sp_addr !== pa || sp_we !== pwe || sp_sel !== psel ||
                              (pwe && sp_wdata !== pwd)))
                unstable = 1;
            if (sp_req && sp_gnt) begin
                o_addr.push_back(sp_addr);
                o_sel.push_back(sp_sel);
                if (sp_we) begin
                    o_sdata.push_back(sp_wdata);
                end else begin
                    d = {$urandom, $urandom, $urandom, $urandom};
                    pend_due.push_back(cyc + rlat);
                    pend_data.push_back(d);
                    exp_ld.push_back(d);
                    outs++;
                end
                wait_cnt = 0; prev_pend = 0;
            end else if (sp_req) begin
                wait_cnt++; prev_pend = 1;
                pa = sp_addr; pwe = sp_we; psel = sp_sel; pwd = sp_wdata;
            end else begin
                wait_cnt = 0; prev_pend = 0;
            end
            if (outs > max_outs) max_outs = outs;
            if (cyc == hold_until - 1) hold_grants = exp_ld.size();
            if (cyc >= 6 && cyc < hold_until && sp_req) req_in_hold = 1;
            if (vrf_we) begin
                o_vbeat.push_back(vrf_beat); o_vvd.push_back(vrf_vd); o_vdata.push_back(vrf_wdata);
            end
            rd_pend = vrf_re; rvd = vrf_vd; rb = vrf_beat;
            if (vrf_re) begin
                o_rbeat.push_back(vrf_beat); o_rvd.push_back(vrf_vd);
            end
            if (done) done_cyc = cyc;
            if (err)  err_cyc = cyc;
        end
        sp_gnt = 1'b0; sp_rvalid = 1'b0;
        if (done_cyc < 0 && err_cyc < 0) timeout = 1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({instr_ready, sp_req, sp_sel, sp_we, vrf_re, vrf_we, busy, done, err} !== 9'b1_0000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 100000000",
                     {instr_ready, sp_req, sp_sel, sp_we, vrf_re, vrf_we, busy, done, err});
        end
        n_checks++;
        if ({sp_addr, sp_wdata, vrf_vd, vrf_beat, vrf_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h beat %h vd %h want all zero", sp_addr, vrf_beat, vrf_vd);
        end
    endtask

    task automatic test_load(input string name, input logic [31:0] ins, input logic [15:0] base,
                             input logic [15:0] vm, input int gdel, input int rlat);
        int exp_done;
        model(ins, base, vm);
        run_op(ins, base, vm, gdel, rlat, 0);
        exp_done = (gdel == 0 && rlat == 1) ? exp_beats.size() + 2 : -1;
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL %s timeout: no done within bound, want done", name); end
        n_checks++;
        if (o_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL %s req_count: got %0d want %0d", name, o_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < o_addr.size(); i++) begin
                n_checks++;
                if (o_addr[i] !== exp_addr[i]) begin
                    n_fail++; $display("FAIL %s addr[%0d]: got %h want %h", name, i, o_addr[i], exp_addr[i]);
                end
                n_checks++;
                if (o_sel[i] !== ins[10]) begin
                    n_fail++; $display("FAIL %s sel[%0d]: got %b want %b", name, i, o_sel[i], ins[10]);
                end
            end
        end
        n_checks++;
        if (o_vbeat.size() != exp_beats.size()) begin
            n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, o_vbeat.size(), exp_beats.size());
        end else begin
            for (int i = 0; i < o_vbeat.size(); i++) begin
                n_checks++;
                if ({o_vbeat[i], o_vvd[i], o_vdata[i]} !== {4'(exp_beats[i]), ins[27:20], exp_ld[i]}) begin
                    n_fail++;
                    $display("FAIL %s vrf_write[%0d]: got beat %0d vd %h data %h want beat %0d vd %h data %h",
                             name, i, o_vbeat[i], o_vvd[i], o_vdata[i], exp_beats[i], ins[27:20], exp_ld[i]);
                end
            end
        end
        n_checks++;
        if (o_sdata.size() != 0 || o_rbeat.size() != 0) begin
            n_fail++; $display("FAIL %s store_activity: got %0d writes %0d reads want 0", name,
                               o_sdata.size(), o_rbeat.size());
        end
        n_checks++;
        if (unstable) begin n_fail++; $display("FAIL %s req_stable: got changed before gnt want held", name); end
        if (exp_done >= 0) begin
            n_checks++;
            if (done_cyc !== exp_done) begin
                n_fail++; $display("FAIL %s done_latency: got %0d want %0d", name, done_cyc, exp_done);
            end
        end
    endtask

    task automatic test_store(input string name, input logic [31:0] ins, input logic [15:0] base,
                              input logic [15:0] vm, input int gdel);
        model(ins, base, vm);
        run_op(ins, base, vm, gdel, 1, 0);
        n_checks++;
        if (timeout || done_cyc < 0) begin
            n_fail++; $display("FAIL %s done: got cycle %0d want a done pulse", name, done_cyc);
        end
        n_checks++;
        if (o_sdata.size() != exp_beats.size() || o_addr.size() != exp_beats.size()) begin
            n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, o_sdata.size(), exp_beats.size());
        end else begin
            for (int i = 0; i < o_sdata.size(); i++) begin
                n_checks++;
                if ({o_addr[i], o_sel[i], o_sdata[i]} !== {exp_addr[i], ins[10], vrf_val(ins[27:20], 4'(exp_beats[i]))}) begin
                    n_fail++;
                    $display("FAIL %s sp_write[%0d]: got addr %h sel %b data %h want addr %h sel %b data %h",
                             name, i, o_addr[i], o_sel[i], o_sdata[i], exp_addr[i], ins[10],
                             vrf_val(ins[27:20], 4'(exp_beats[i])));
                end
            end
        end
        n_checks++;
        if (o_rbeat.size() != exp_beats.size()) begin
            n_fail++; $display("FAIL %s read_count: got %0d want %0d", name, o_rbeat.size(), exp_beats.size());
        end else begin
            for (int i = 0; i < o_rbeat.size(); i++) begin
                n_checks++;
                if ({o_rbeat[i], o_rvd[i]} !== {4'(exp_beats[i]), ins[27:20]}) begin
                    n_fail++; $display("FAIL %s vrf_read[%0d]: got beat %0d vd %h want beat %0d vd %h",
                                       name, i, o_rbeat[i], o_rvd[i], exp_beats[i], ins[27:20]);
                end
            end
        end
        n_checks++;
        if (o_vbeat.size() != 0) begin n_fail++; $display("FAIL %s vrf_we: got %0d want 0", name, o_vbeat.size()); end
        n_checks++;
        if (unstable) begin n_fail++; $display("FAIL %s req_stable: got changed before gnt want held", name); end
    endtask

    task automatic test_back_to_back_outstanding();
        logic [31:0] ins;
        ins = mk_instr(1'b0, 1'b0, 8'h21, 1'b0, 1'b0, OP_LD);
        run_op(ins, 16'h0300, 16'h0000, 0, 1, 12);
        n_checks++;
        if (hold_grants !== 4) begin n_fail++; $display("FAIL outstanding_grants: got %0d want 4", hold_grants); end
        n_checks++;
        if (req_in_hold) begin n_fail++; $display("FAIL outstanding_req: got sp_req=1 while full want 0"); end
        n_checks++;
        if (max_outs !== 4) begin n_fail++; $display("FAIL outstanding_max: got %0d want 4", max_outs); end
        n_checks++;
        if (o_vbeat.size() != 16 || done_cyc < 0) begin
            n_fail++; $display("FAIL outstanding_writes: got %0d done %0d want 16 and done", o_vbeat.size(), done_cyc);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if ({o_vbeat[i], o_vdata[i]} !== {4'(i), exp_ld[i]}) begin
                    n_fail++; $display("FAIL outstanding_order[%0d]: got beat %0d want %0d", i, o_vbeat[i], i);
                end
            end
        end
    endtask

    task automatic test_illegal();
        run_op(mk_instr(1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 7'h7F), 16'h0100, 16'h0, 0, 1, 0);
        n_checks++;
        if (err_cyc !== 1) begin n_fail++; $display("FAIL illegal_err: got cycle %0d want 1", err_cyc); end
        n_checks++;
        if (o_addr.size() != 0 || o_vbeat.size() != 0 || done_cyc != -1) begin
            n_fail++; $display("FAIL illegal_side: got %0d reqs %0d writes done %0d want none",
                               o_addr.size(), o_vbeat.size(), done_cyc);
        end
    endtask

    task automatic test_reset_midload();
        int wes = 0;
        @(negedge CLK);
        instr_valid = 1'b1; instr = mk_instr(1'b0, 1'b0, 8'h33, 1'b0, 1'b0, OP_LD);
        base_addr = 16'h0400; vmask = '0; sp_rvalid = 1'b0;
        @(posedge CLK);
        #1 instr_valid = 1'b0;
        repeat (3) begin @(negedge CLK); sp_gnt = sp_req; end
        @(negedge CLK);
        sp_gnt = 1'b0; nRST = 1'b0;
        #1;
        n_checks++;
        if ({instr_ready, sp_req, sp_we, vrf_re, vrf_we, busy, done, err} !== 8'b1000_0000) begin
            n_fail++; $display("FAIL midreset_ctrl: got %b want 10000000",
                               {instr_ready, sp_req, sp_we, vrf_re, vrf_we, busy, done, err});
        end
        n_checks++;
        if (sp_addr !== 16'h0) begin n_fail++; $display("FAIL midreset_addr: got %h want 0000", sp_addr); end
        @(negedge CLK);
        nRST = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            sp_rvalid = 1'b1; sp_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1 if (vrf_we) wes++;
        end
        @(negedge CLK);
        sp_rvalid = 1'b0;
        n_checks++;
        if (wes !== 0) begin n_fail++; $display("FAIL midreset_late_rvalid: got %0d vrf writes want 0", wes); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic        st;
        for (int k = 0; k < 12; k++) begin
            st  = 1'($urandom_range(0, 1));
            ins = mk_instr(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                           st ? OP_ST : OP_LD);
            if (st) test_store("rand_st", ins, 16'($urandom), 16'($urandom), $urandom_range(0, 2));
            else    test_load("rand_ld", ins, 16'($urandom), 16'($urandom), $urandom_range(0, 3),
                              $urandom_range(1, 4));
        end
    endtask

    initial begin
        nRST = 1'b0; instr_valid = 1'b0; instr = '0; base_addr = '0; vmask = '0;
        sp_gnt = 1'b0; sp_rvalid = 1'b0; sp_rdata = '0; vrf_rdata = '0;
        repeat (3) @(negedge CLK);
        #1 test_reset();
        @(negedge CLK);
        nRST = 1'b1;
        test_load("basic", mk_instr(1'b0, 1'b0, 8'h05, 1'b0, 1'b0, OP_LD), 16'h0100, 16'h0, 0, 1);
        test_load("transpose", mk_instr(1'b0, 1'b1, 8'h06, 1'b0, 1'b0, OP_LD), 16'h0100, 16'h0, 0, 1);
        test_load("wrap", mk_instr(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, OP_LD), 16'hFF80, 16'h0, 0, 1);
        test_load("vmask5", mk_instr(1'b0, 1'b0, 8'h08, 1'b1, 1'b0, OP_LD), 16'h0100, 16'h0005, 0, 1);
        test_load("vmask0", mk_instr(1'b0, 1'b0, 8'h09, 1'b1, 1'b0, OP_LD), 16'h0100, 16'h0000, 0, 1);
        test_back_to_back_outstanding();
        test_store("store_swz", mk_instr(1'b1, 1'b0, 8'h0A, 1'b0, 1'b1, OP_ST), 16'h0200, 16'h0, 3);
        test_store("store_vmask0", mk_instr(1'b0, 1'b0, 8'h0B, 1'b1, 1'b0, OP_ST), 16'h0200, 16'h0, 0);
        test_illegal();
        test_reset_midload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
